seq_alu: RTL and testbench
==========================

Name: seq_alu

Overview:
- Parametrised, registered successor to the single-cycle combinational ALU.
- Same operation encoding, plus a valid/ready handshake and iterative multi-cycle multiply/divide that produce full HI/LO results for MIPS mult/div.
- Sits between the decode/issue stage and writeback.
- The pipeline stalls on in_ready low while a multiply or divide is iterating.

Parameters:
- WIDTH, 32, operand/result width in bits; must be even, >= 8.
- CONTROL_LENGTH, 4, width of the operation code.
- SHAMT_W, $clog2(WIDTH), number of low bits of a used as shift amount.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operands and control are valid.
- in_ready  output  1  block can accept an operation; high only in IDLE.
- a  input  WIDTH  operand A (shift amount for shift ops).
- b  input  WIDTH  operand B.
- control  input  CONTROL_LENGTH  operation code.
- out_valid  output  1  result registers hold a completed result.
- out_ready  input  1  consumer takes the result.
- result  output  WIDTH  main result; LO for mult (low product) and div (quotient).
- result_hi  output  WIDTH  HI: product upper half, or remainder; 0 for all other ops.
- div_by_zero  output  1  set with the result of a divide whose b == 0.

Behaviour:
- Interface: one clock (clk); reset rst is asynchronous, active-high.
- Reset (any time, including mid-iteration):
  - state=IDLE, iteration counter=0.
  - result, result_hi, div_by_zero, out_valid=0; in_ready=1 once rst deasserts.
  - Any in-flight operation is discarded.
- Accept: edge where in_valid && in_ready. Operands latched; input changes afterwards have no effect.
- Opcodes:
  - 0 signed add; 1 signed sub; 2 unsigned add; 3 unsigned sub (all wrap modulo 2^WIDTH).
  - 4 and; 5 xor; 6 nor; 7 b<<a[SHAMT_W-1:0]; 8 logical b>>a[SHAMT_W-1:0].
  - 9 signed a<b, zero-extended to WIDTH; 10 signed mult; 11 signed div.
  - 12 arithmetic b>>>a[SHAMT_W-1:0]; 13 or; 14 b<<(WIDTH/2); 15 result 0.
- FSM states IDLE, MUL, DIV, FIX, DONE.
  - IDLE -> DONE: single-cycle op, result registered at the accept edge. out_valid high the cycle after accept.
  - IDLE -> MUL/DIV: op 10/11 with b != 0. Latch |a|, |b|, result sign; counter=WIDTH.
  - MUL/DIV: one shift-add or restoring-subtract step per edge. Counter decrements each step; exit to FIX when it reaches 0.
  - FIX -> DONE: apply sign correction. out_valid is first seen WIDTH+2 cycles after the accept edge.
  - Divide with b == 0: IDLE -> DONE directly. result = all ones, result_hi = a, div_by_zero=1.
  - DONE: outputs held stable while out_valid && !out_ready. The out_valid && out_ready edge returns to IDLE and clears out_valid. No new accept on that same edge.
- Arithmetic:
  - mult: full 2*WIDTH signed product, split into {result_hi, result}.
  - div: quotient truncates toward zero; remainder takes the dividend's sign.
  - MIN / -1: result=MIN, result_hi=0, no flag.
- div_by_zero is cleared on every accept.
- result_hi is 0 for all non-mult/div ops.

Optional Feature:
- Macro SEQ_ALU_OVERFLOW_EN.
- Defined:
  - Adds output port overflow (1 bit), reset 0.
  - Set with the result of ops 0/1 when signed overflow occurs (operand signs agree for add / differ for sub, and result sign differs from a); 0 for all other ops.
  - Result value is still the wrapped sum.
- Undefined: no overflow port and no logic; all other behaviour identical.

Test Plan:
- Reset mid-MUL: accept op 10 a=7 b=6, assert rst after 5 cycles -> out_valid=0 and result=0 immediately; in_ready=1 after release; no stale result appears.
- Single-cycle ops, out_ready tied 1:
  - op 0 a=5 b=0xFFFFFFFD -> result=2, out_valid 1 cycle after accept.
  - op 12 a=4 b=0x80000000 -> 0xF8000000.
  - op 9 a=-1 b=1 -> 1.
- Multiply: op 10 a=0xFFFFFFFE(-2) b=3 -> result=0xFFFFFFFA, result_hi=0xFFFFFFFF. out_valid exactly 34 cycles after accept; in_ready low throughout.
- Divide:
  - op 11 a=-7 b=2 -> result=0xFFFFFFFD(-3), result_hi=0xFFFFFFFF(-1).
  - a=0x80000000 b=-1 -> result=0x80000000, result_hi=0.
  - a=9 b=0 -> result=0xFFFFFFFF, result_hi=9, div_by_zero=1, latency 1.
- Backpressure: out_ready held 0 for 10 cycles after op 13 a=0xF0 b=0x0F -> result=0xFF stable, out_valid high, in_valid ignored; release -> one transfer, in_ready 1 next cycle.
- With SEQ_ALU_OVERFLOW_EN: op 0 a=0x7FFFFFFF b=1 -> result=0x80000000, overflow=1; op 2 with same operands -> overflow=0.

Source files
------------

// File: rtl/seq_alu.sv
// seq_alu: registered ALU with a valid/ready handshake and iterative
// signed multiply (shift-add) / divide (restoring) producing HI/LO results.
// Optional macro SEQ_ALU_OVERFLOW_EN adds the signed-overflow output.
module seq_alu #(
   parameter int WIDTH          = 32,
   parameter int CONTROL_LENGTH = 4,
   parameter int SHAMT_W        = $clog2(WIDTH)
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [WIDTH-1:0]          a,
   input  logic [WIDTH-1:0]          b,
   input  logic [CONTROL_LENGTH-1:0] control,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [WIDTH-1:0]          result,
   output logic [WIDTH-1:0]          result_hi,
   output logic                      div_by_zero
`ifdef SEQ_ALU_OVERFLOW_EN
   ,
   output logic                      overflow
`endif
);

   localparam int CNT_W = $clog2(WIDTH + 1);

   localparam logic [CONTROL_LENGTH-1:0] OP_SADD = CONTROL_LENGTH'(0);
   localparam logic [CONTROL_LENGTH-1:0] OP_SSUB = CONTROL_LENGTH'(1);
   localparam logic [CONTROL_LENGTH-1:0] OP_UADD = CONTROL_LENGTH'(2);
   localparam logic [CONTROL_LENGTH-1:0] OP_USUB = CONTROL_LENGTH'(3);
   localparam logic [CONTROL_LENGTH-1:0] OP_AND  = CONTROL_LENGTH'(4);
   localparam logic [CONTROL_LENGTH-1:0] OP_XOR  = CONTROL_LENGTH'(5);
   localparam logic [CONTROL_LENGTH-1:0] OP_NOR  = CONTROL_LENGTH'(6);
   localparam logic [CONTROL_LENGTH-1:0] OP_SLL  = CONTROL_LENGTH'(7);
   localparam logic [CONTROL_LENGTH-1:0] OP_SRL  = CONTROL_LENGTH'(8);
   localparam logic [CONTROL_LENGTH-1:0] OP_SLT  = CONTROL_LENGTH'(9);
   localparam logic [CONTROL_LENGTH-1:0] OP_MULT = CONTROL_LENGTH'(10);
   localparam logic [CONTROL_LENGTH-1:0] OP_DIV  = CONTROL_LENGTH'(11);
   localparam logic [CONTROL_LENGTH-1:0] OP_SRA  = CONTROL_LENGTH'(12);
   localparam logic [CONTROL_LENGTH-1:0] OP_OR   = CONTROL_LENGTH'(13);
   localparam logic [CONTROL_LENGTH-1:0] OP_LUI  = CONTROL_LENGTH'(14);

   typedef enum logic [2:0] {IDLE, MUL, DIV, FIX, DONE} state_t;

   state_t             state;
   logic [CNT_W-1:0]   cnt;
   logic [WIDTH-1:0]   acc_hi;    // partial product high half / partial remainder
   logic [WIDTH-1:0]   acc_lo;    // multiplier bits / dividend-quotient bits
   logic [WIDTH-1:0]   opnd;      // |multiplicand| or |divisor|
   logic               neg_lo;    // negate LO (or the full product for mult)
   logic               neg_hi;    // negate remainder (dividend sign)
   logic               is_div;

   logic [WIDTH-1:0]   alu_res;
   logic [SHAMT_W-1:0] shamt;
   logic [WIDTH:0]     mul_sum;
   logic [WIDTH:0]     div_shift;
   logic [WIDTH:0]     div_diff;
   logic [2*WIDTH-1:0] prod_neg;
`ifdef SEQ_ALU_OVERFLOW_EN
   logic               ovf_res;
`endif

   function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v);
      return v[WIDTH-1] ? -v : v;
   endfunction

   // single-cycle operation result from the live inputs
   always_comb begin
      alu_res = '0;
      shamt   = a[SHAMT_W-1:0];
      case (control)
         OP_SADD, OP_UADD: alu_res = a + b;
         OP_SSUB, OP_USUB: alu_res = a - b;
         OP_AND:           alu_res = a & b;
         OP_XOR:           alu_res = a ^ b;
         OP_NOR:           alu_res = ~(a | b);
         OP_SLL:           alu_res = b << shamt;
         OP_SRL:           alu_res = b >> shamt;
         OP_SLT:           alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
         OP_SRA:           alu_res = $unsigned($signed(b) >>> shamt);
         OP_OR:            alu_res = a | b;
         OP_LUI:           alu_res = b << (WIDTH / 2);
         default:          alu_res = '0;
      endcase
   end

`ifdef SEQ_ALU_OVERFLOW_EN
   // signed overflow for ops 0/1, judged against the wrapped result
   always_comb begin
      ovf_res = 1'b0;
      if (control == OP_SADD)
         ovf_res = (a[WIDTH-1] == b[WIDTH-1]) && (alu_res[WIDTH-1] != a[WIDTH-1]);
      else if (control == OP_SSUB)
         ovf_res = (a[WIDTH-1] != b[WIDTH-1]) && (alu_res[WIDTH-1] != a[WIDTH-1]);
   end
`endif

   // datapath for one multiply/divide iteration and the final negation
   always_comb begin
      mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);
      div_shift = {acc_hi, acc_lo[WIDTH-1]};
      div_diff  = div_shift - {1'b0, opnd};
      prod_neg  = -{acc_hi, acc_lo};
   end

   // handshake FSM, iteration sequencing and registered outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         cnt         <= '0;
         acc_hi      <= '0;
         acc_lo      <= '0;
         opnd        <= '0;
         neg_lo      <= 1'b0;
         neg_hi      <= 1'b0;
         is_div      <= 1'b0;
         result      <= '0;
         result_hi   <= '0;
         div_by_zero <= 1'b0;
         out_valid   <= 1'b0;
         in_ready    <= 1'b1;
`ifdef SEQ_ALU_OVERFLOW_EN
         overflow    <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (in_valid && in_ready) begin
                  in_ready    <= 1'b0;
                  div_by_zero <= 1'b0;
`ifdef SEQ_ALU_OVERFLOW_EN
                  overflow    <= 1'b0;
`endif
                  if (control == OP_DIV && b == '0) begin
                     result      <= '1;
                     result_hi   <= a;
                     div_by_zero <= 1'b1;
                     out_valid   <= 1'b1;
                     state       <= DONE;
                  end else if (control == OP_MULT || control == OP_DIV) begin
                     is_div <= (control == OP_DIV);
                     neg_lo <= a[WIDTH-1] ^ b[WIDTH-1];
                     neg_hi <= (control == OP_DIV) ? a[WIDTH-1] : (a[WIDTH-1] ^ b[WIDTH-1]);
                     acc_hi <= '0;
                     cnt    <= CNT_W'(WIDTH);
                     if (control == OP_DIV) begin
                        acc_lo <= mag(a);
                        opnd   <= mag(b);
                        state  <= DIV;
                     end else begin
                        acc_lo <= mag(b);
                        opnd   <= mag(a);
                        state  <= MUL;
                     end
                  end else begin
                     result    <= alu_res;
                     result_hi <= '0;
`ifdef SEQ_ALU_OVERFLOW_EN
                     overflow  <= ovf_res;
`endif
                     out_valid <= 1'b1;
                     state     <= DONE;
                  end
               end
            end
            MUL: begin
               acc_hi <= mul_sum[WIDTH:1];
               acc_lo <= {mul_sum[0], acc_lo[WIDTH-1:1]};
               cnt    <= cnt - CNT_W'(1);
               if (cnt == CNT_W'(1))
                  state <= FIX;
            end
            DIV: begin
               if (!div_diff[WIDTH]) begin
                  acc_hi <= div_diff[WIDTH-1:0];
                  acc_lo <= {acc_lo[WIDTH-2:0], 1'b1};
               end else begin
                  acc_hi <= div_shift[WIDTH-1:0];
                  acc_lo <= {acc_lo[WIDTH-2:0], 1'b0};
               end
               cnt <= cnt - CNT_W'(1);
               if (cnt == CNT_W'(1))
                  state <= FIX;
            end
            FIX: begin
               // Magnitudes were computed unsigned; signs are restored here.
               // Mult negates the whole 2*WIDTH product, div each half alone.
               if (is_div) begin
                  result    <= neg_lo ? -acc_lo : acc_lo;
                  result_hi <= neg_hi ? -acc_hi : acc_hi;
               end else if (neg_lo) begin
                  {result_hi, result} <= prod_neg;
               end else begin
                  {result_hi, result} <= {acc_hi, acc_lo};
               end
               out_valid <= 1'b1;
               state     <= DONE;
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_seq_alu.sv
// tb_seq_alu: directed vectors with hand-computed expectations for seq_alu.
module tb_seq_alu;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] a = '0;
   logic [31:0] b = '0;
   logic [3:0]  control = '0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [31:0] result;
   logic [31:0] result_hi;
   logic        div_by_zero;
`ifdef SEQ_ALU_OVERFLOW_EN
   logic        overflow;
`endif

   int n_vec = 0;
   int n_err = 0;

   seq_alu #(.WIDTH(32), .CONTROL_LENGTH(4)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .control(control), .out_valid(out_valid),
      .out_ready(out_ready), .result(result), .result_hi(result_hi),
      .div_by_zero(div_by_zero)
`ifdef SEQ_ALU_OVERFLOW_EN
      , .overflow(overflow)
`endif
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // wait for in_ready, present one operation, then scramble inputs after accept
   task automatic send_op(input logic [3:0] op, input logic [31:0] ia, input logic [31:0] ib);
      int guard = 0;
      while (!in_ready && guard < 100) begin
         @(posedge clk); #1;
         guard++;
      end
      if (!in_ready) check("ready_timeout", 64'(in_ready), 64'd1);
      control  = op;
      a        = ia;
      b        = ib;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      a        = $urandom;
      b        = $urandom;
      control  = 4'($urandom);
   endtask

   // send and wait for out_valid; lat=1 means visible right after the accept edge
   task automatic run_op(input logic [3:0] op, input logic [31:0] ia, input logic [31:0] ib,
                         output int lat, output bit busy_ok);
      send_op(op, ia, ib);
      lat     = 1;
      busy_ok = 1'b1;
      while (!out_valid && lat < 200) begin
         if (in_ready) busy_ok = 1'b0;
         @(posedge clk); #1;
         lat++;
      end
   endtask

   task automatic do_op(input string tag, input logic [3:0] op, input logic [31:0] ia,
                        input logic [31:0] ib, input logic [31:0] elo, input logic [31:0] ehi,
                        input logic edbz, input int elat);
      int lat;
      bit busy_ok;
      run_op(op, ia, ib, lat, busy_ok);
      check({tag, ".valid"}, 64'(out_valid), 64'd1);
      check({tag, ".lo"}, 64'(result), 64'(elo));
      check({tag, ".hi"}, 64'(result_hi), 64'(ehi));
      check({tag, ".dbz"}, 64'(div_by_zero), 64'(edbz));
      check({tag, ".lat"}, 64'(lat), 64'(elat));
      check({tag, ".busy"}, 64'(busy_ok), 64'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int  lat;
      bit  busy_ok;
      bit  stale;

      // power-on reset
      #12;
      check("rst.valid", 64'(out_valid), 64'd0);
      check("rst.lo", 64'(result), 64'd0);
      check("rst.hi", 64'(result_hi), 64'd0);
      check("rst.dbz", 64'(div_by_zero), 64'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      check("rst.ready", 64'(in_ready), 64'd1);

      // single-cycle ops
      do_op("add",   4'd0,  32'd5,        32'hFFFFFFFD, 32'd2,        '0, 1'b0, 1);
      do_op("sra",   4'd12, 32'd4,        32'h80000000, 32'hF8000000, '0, 1'b0, 1);
      do_op("slt",   4'd9,  32'hFFFFFFFF, 32'd1,        32'd1,        '0, 1'b0, 1);
      do_op("slt2",  4'd9,  32'd1,        32'hFFFFFFFF, 32'd0,        '0, 1'b0, 1);
      do_op("sll",   4'd7,  32'h24,       32'd1,        32'h10,       '0, 1'b0, 1);
      do_op("srl",   4'd8,  32'd4,        32'h80000000, 32'h08000000, '0, 1'b0, 1);
      do_op("nor",   4'd6,  32'hF0F0F0F0, 32'h0F0F0000, 32'h00000F0F, '0, 1'b0, 1);
      do_op("lui",   4'd14, 32'd0,        32'h1234,     32'h12340000, '0, 1'b0, 1);
      do_op("sub",   4'd1,  32'd3,        32'd5,        32'hFFFFFFFE, '0, 1'b0, 1);
      do_op("xor",   4'd5,  32'hFF00FF00, 32'h0FF00FF0, 32'hF0F0F0F0, '0, 1'b0, 1);
      do_op("usub",  4'd3,  32'd0,        32'd1,        32'hFFFFFFFF, '0, 1'b0, 1);
      do_op("and",   4'd4,  32'hFFFF0000, 32'h12345678, 32'h12340000, '0, 1'b0, 1);
      do_op("zero",  4'd15, 32'd123,      32'd456,      32'd0,        '0, 1'b0, 1);

      // multiply
      do_op("mul_n2x3",   4'd10, 32'hFFFFFFFE, 32'd3,        32'hFFFFFFFA, 32'hFFFFFFFF, 1'b0, 34);
      do_op("mul_7x6",    4'd10, 32'd7,        32'd6,        32'd42,       32'd0,        1'b0, 34);
      do_op("mul_minmin", 4'd10, 32'h80000000, 32'h80000000, 32'd0,        32'h40000000, 1'b0, 34);
      do_op("mul_maxn1",  4'd10, 32'h7FFFFFFF, 32'hFFFFFFFF, 32'h80000001, 32'hFFFFFFFF, 1'b0, 34);
      do_op("or_after_mul", 4'd13, 32'h1, 32'h2, 32'h3, 32'd0, 1'b0, 1);

      // divide
      do_op("div_n7d2",   4'd11, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0, 34);
      do_op("div_7dn2",   4'd11, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 32'd1,        1'b0, 34);
      do_op("div_minn1",  4'd11, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0,        1'b0, 34);
      do_op("div_9d0",    4'd11, 32'd9,        32'd0,        32'hFFFFFFFF, 32'd9,        1'b1, 1);
      do_op("div_100d7",  4'd11, 32'd100,      32'd7,        32'd14,       32'd2,        1'b0, 34);

      // reset in the middle of a multiply
      send_op(4'd10, 32'd7, 32'd6);
      repeat (4) @(posedge clk);
      #3 rst = 1'b1;
      #1;
      check("midrst.valid", 64'(out_valid), 64'd0);
      check("midrst.lo", 64'(result), 64'd0);
      check("midrst.hi", 64'(result_hi), 64'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      check("midrst.ready", 64'(in_ready), 64'd1);
      stale = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk); #1;
         if (out_valid) stale = 1'b1;
      end
      check("midrst.stale", 64'(stale), 64'd0);
      do_op("after_rst", 4'd0, 32'd10, 32'd20, 32'd30, '0, 1'b0, 1);

      // backpressure: result held, new requests ignored
      @(posedge clk); #1;
      out_ready = 1'b0;
      send_op(4'd13, 32'hF0, 32'h0F);
      control  = 4'd15;
      a        = 32'd1;
      b        = 32'd1;
      in_valid = 1'b1;
      for (int i = 0; i < 10; i++) begin
         check("bp.valid", 64'(out_valid), 64'd1);
         check("bp.lo", 64'(result), 64'hFF);
         check("bp.ready", 64'(in_ready), 64'd0);
         @(posedge clk); #1;
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      check("bp.xfer_valid", 64'(out_valid), 64'd0);
      check("bp.xfer_ready", 64'(in_ready), 64'd1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      check("bp.next_valid", 64'(out_valid), 64'd1);
      check("bp.next_lo", 64'(result), 64'd0);

`ifdef SEQ_ALU_OVERFLOW_EN
      run_op(4'd0, 32'h7FFFFFFF, 32'd1, lat, busy_ok);
      check("ovf.add.lo", 64'(result), 64'h80000000);
      check("ovf.add", 64'(overflow), 64'd1);
      run_op(4'd2, 32'h7FFFFFFF, 32'd1, lat, busy_ok);
      check("ovf.uadd.lo", 64'(result), 64'h80000000);
      check("ovf.uadd", 64'(overflow), 64'd0);
      run_op(4'd1, 32'h80000000, 32'd1, lat, busy_ok);
      check("ovf.sub.lo", 64'(result), 64'h7FFFFFFF);
      check("ovf.sub", 64'(overflow), 64'd1);
`endif

      @(posedge clk); #1;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
